// File: rtl/conv_acc_pkg.sv
// Shared definitions for the EPU conv accelerator: mode bit indices,
// descriptor layout, opcode and sequencer state enums.
package conv_acc_pkg;

   localparam int unsigned IDLE_MODE     = 0;
   localparam int unsigned CONV_3X3_MODE = 1;
   localparam int unsigned FC_MODE       = 2;
   localparam int unsigned MAX_POOL_MODE = 3;

   localparam logic [3:0] MODE_IDLE = 4'b0001 << IDLE_MODE;

   localparam int unsigned DESC_OP_LSB  = 0;
   localparam int unsigned DESC_OP_MSB  = 1;
   localparam int unsigned DESC_REP_LSB = 8;
   localparam int unsigned DESC_REP_MSB = 15;

   typedef enum logic [1:0] {
      OP_CONV_3x3 = 2'b00,
      OP_FC       = 2'b01,
      OP_MAX_POOL = 2'b10,
      OP_END      = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_SWITCH,
      S_RUN,
      S_FINISH
   } state_e;

   function automatic logic [3:0] op_to_mode(input op_e op);
      logic [3:0] m;
      m = '0;
      unique case (op)
         OP_CONV_3x3: m[CONV_3X3_MODE] = 1'b1;
         OP_FC:       m[FC_MODE]       = 1'b1;
         OP_MAX_POOL: m[MAX_POOL_MODE] = 1'b1;
         OP_END:      m[IDLE_MODE]     = 1'b1;
         default:     m[IDLE_MODE]     = 1'b1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/layer_watchdog.sv
// RUN-phase watchdog: counts enabled cycles from a clear and flags the
// (2^TO_W-1)th enabled cycle.
module layer_watchdog #(
   parameter int unsigned TO_W = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam logic [TO_W-1:0] ALL_ONES = '1;
   localparam logic [TO_W-1:0] LAST     = ALL_ONES - TO_W'(1);

   logic [TO_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != ALL_ONES)) begin
         r_cnt <= r_cnt + TO_W'(1);
      end
   end

   // r_cnt holds the number of earlier enabled cycles, so LAST marks the limit cycle
   assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/epu_layer_sequencer.sv
// Layer-program sequencer: fetches descriptors, steers the conv bus switcher
// mode, starts each unit and waits for its done, stopping on END or error.
module epu_layer_sequencer
   import conv_acc_pkg::*;
#(
   parameter int unsigned DESC_AW = 6,
   parameter int unsigned TO_W    = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [DESC_AW-1:0] base_addr,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [DESC_AW-1:0] layer_idx,
   output logic [3:0]         mode,
   output logic               unit_start,
   input  logic               unit_done,
   output logic               desc_cs,
   output logic               desc_oe,
   output logic [DESC_AW-1:0] desc_addr,
   input  logic [31:0]        desc_rdata
);

   state_e             r_state, w_state_nxt;
   logic [DESC_AW-1:0] r_addr;
   op_e                r_op;
   logic [7:0]         r_rep;
   logic               r_err;
   logic               r_first;
   logic               w_expire;
   logic               w_done_ok;
   logic               w_err_set;
   op_e                w_op;
   logic [7:0]         w_rep;
   logic [21:0]        w_unused_desc;

   assign w_op          = op_e'(desc_rdata[DESC_OP_MSB:DESC_OP_LSB]);
   assign w_rep         = desc_rdata[DESC_REP_MSB:DESC_REP_LSB];
   assign w_unused_desc = {desc_rdata[31:16], desc_rdata[7:2]};

   // unit_done is only meaningful after the unit_start cycle of a RUN
   assign w_done_ok = (r_state == S_RUN) && !r_first && unit_done;

   layer_watchdog #(.TO_W(TO_W)) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    (r_state != S_RUN),
      .i_en     (r_state == S_RUN),
      .o_expire (w_expire)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_err_set   = 1'b0;
      unique case (r_state)
         S_IDLE:   if (start) w_state_nxt = S_FETCH;
         S_FETCH:  w_state_nxt = S_DECODE;
         S_DECODE: w_state_nxt = (w_op == OP_END) ? S_FINISH : S_SWITCH;
         S_SWITCH: w_state_nxt = S_RUN;
         S_RUN: begin
            if (w_done_ok) begin
               if (r_rep > 8'd1) begin
                  w_state_nxt = S_SWITCH;
               end else if (r_addr == '1) begin
                  w_err_set   = 1'b1;
                  w_state_nxt = S_FINISH;
               end else begin
                  w_state_nxt = S_FETCH;
               end
            end else if (w_expire) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_FINISH;
            end
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_op    <= OP_CONV_3x3;
         r_rep   <= '0;
         r_err   <= 1'b0;
         r_first <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_first <= (r_state == S_SWITCH);
         if ((r_state == S_IDLE) && start) begin
            r_addr <= base_addr;
            r_err  <= 1'b0;
         end
         if (r_state == S_DECODE) begin
            r_op  <= w_op;
            r_rep <= (w_rep == '0) ? 8'd1 : w_rep;
         end
         if (w_done_ok) begin
            if (r_rep > 8'd1) begin
               r_rep <= r_rep - 8'd1;
            end else if (r_addr != '1) begin
               r_addr <= r_addr + DESC_AW'(1);
            end
         end
         if (w_err_set) r_err <= 1'b1;
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_FINISH);
   assign err        = r_err;
   assign layer_idx  = r_addr;
   assign desc_addr  = r_addr;
   assign desc_cs    = (r_state == S_FETCH);
   assign desc_oe    = (r_state == S_FETCH);
   assign unit_start = (r_state == S_RUN) && r_first;
   assign mode       = ((r_state == S_SWITCH) || (r_state == S_RUN)) ? op_to_mode(r_op)
                                                                     : MODE_IDLE;

endmodule
